// File: rtl/alarm_unit.sv
// Alarm stage: settable HH:MM alarm, rising-edge match against the running time,
// and a ring/snooze state machine driving a beeping buzzer.
module alarm_unit #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [3:0] hrT,
  input  logic [3:0] hrU,
  input  logic [3:0] minT,
  input  logic [3:0] minU,
  input  logic [3:0] secT,
  input  logic [3:0] secU,
  input  logic       alarm_en,
  input  logic       alarm_set,
  input  logic       select,
  input  logic       increment,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] aHrT,
  output logic [3:0] aHrU,
  output logic [3:0] aMinT,
  output logic [3:0] aMinU,
  output logic [3:0] sel,
  output logic       set_mode,
  output logic       ringing,
  output logic       buzzer
);

  localparam int SNZ_TICKS = SNOOZE_MINUTES * 60;
  localparam int RW        = $clog2(RING_SECONDS + 1);
  localparam int SW        = $clog2(SNZ_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SET, S_RINGING, S_SNOOZE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      hr_t_q, hr_t_d, hr_u_q, hr_u_d;
  logic [3:0]      min_t_q, min_t_d, min_u_q, min_u_d;
  logic [3:0]      sel_q, sel_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
  logic            beep_q, beep_d;
  logic            match_q;
  logic            match_now, trigger;

  assign match_now = alarm_en &&
                     hrT == hr_t_q && hrU == hr_u_q &&
                     minT == min_t_q && minU == min_u_q &&
                     secT == 4'd0 && secU == 4'd0;
  // match_q resets high so an alarm of 00:00 cannot fire straight out of reset.
  assign trigger = match_now && !match_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d    = state_q;
    hr_t_d     = hr_t_q;
    hr_u_d     = hr_u_q;
    min_t_d    = min_t_q;
    min_u_d    = min_u_q;
    sel_d      = sel_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    beep_d     = beep_q;

    unique case (state_q)
      S_IDLE: begin
        if (alarm_set) begin
          state_d = S_SET;
          sel_d   = 4'b0001;
        end else if (trigger) begin
          state_d    = S_RINGING;
          ring_cnt_d = '0;
          beep_d     = 1'b1;
        end
      end

      S_SET: begin
        if (alarm_set) begin
          state_d = S_IDLE;
          sel_d   = 4'b0000;
        end else begin
          // Increment acts on the current selection; a simultaneous select rotates afterwards.
          if (increment) begin
            unique case (sel_q)
              4'b0001: min_u_d = (min_u_q >= 4'd9) ? 4'd0 : min_u_q + 4'd1;
              4'b0010: min_t_d = (min_t_q >= 4'd5) ? 4'd0 : min_t_q + 4'd1;
              4'b0100: begin
                if (hr_t_q == 4'd2) hr_u_d = (hr_u_q >= 4'd3) ? 4'd0 : hr_u_q + 4'd1;
                else                hr_u_d = (hr_u_q >= 4'd9) ? 4'd0 : hr_u_q + 4'd1;
              end
              4'b1000: begin
                if (hr_t_q >= 4'd2) begin
                  hr_t_d = 4'd0;
                end else begin
                  hr_t_d = hr_t_q + 4'd1;
                  if (hr_t_q == 4'd1 && hr_u_q > 4'd3) hr_u_d = 4'd3;
                end
              end
              default: ;
            endcase
          end
          if (select) sel_d = {sel_q[2:0], sel_q[3]};
        end
      end

      S_RINGING: begin
        if (stop || !alarm_en) begin
          state_d = S_IDLE;
          beep_d  = 1'b0;
        end else if (snooze) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SW'(SNZ_TICKS);
          beep_d    = 1'b0;
        end else if (tick) begin
          if (ring_cnt_q == RW'(RING_SECONDS - 1)) begin
            state_d = S_IDLE;
            beep_d  = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
            beep_d     = !beep_q;
          end
        end
      end

      S_SNOOZE: begin
        if (stop || !alarm_en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (snz_cnt_q == SW'(1)) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end
          snz_cnt_d = snz_cnt_q - SW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hr_t_q     <= '0;
      hr_u_q     <= '0;
      min_t_q    <= '0;
      min_u_q    <= '0;
      sel_q      <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      beep_q     <= 1'b0;
      match_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hr_t_q     <= hr_t_d;
      hr_u_q     <= hr_u_d;
      min_t_q    <= min_t_d;
      min_u_q    <= min_u_d;
      sel_q      <= sel_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_q     <= beep_d;
      match_q    <= match_now;
    end
  end

  assign aHrT     = hr_t_q;
  assign aHrU     = hr_u_q;
  assign aMinT    = min_t_q;
  assign aMinU    = min_u_q;
  assign sel      = sel_q;
  assign set_mode = (state_q == S_SET);
  assign ringing  = (state_q == S_RINGING);
  assign buzzer   = ringing && beep_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Self-checking bench for alarm_unit: expected output bundles are queued as stimulus
// is applied and compared once the DUT has responded.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tick, alarm_en, alarm_set, select, increment, stop, snooze;
  logic [3:0] hrT, hrU, minT, minU, secT, secU;
  logic [3:0] aHrT, aHrU, aMinT, aMinU, sel;
  logic       set_mode, ringing, buzzer;

  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  alarm_unit dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .hrT(hrT), .hrU(hrU), .minT(minT), .minU(minU), .secT(secT), .secU(secU),
    .alarm_en(alarm_en), .alarm_set(alarm_set), .select(select),
    .increment(increment), .stop(stop), .snooze(snooze),
    .aHrT(aHrT), .aHrU(aHrU), .aMinT(aMinT), .aMinU(aMinU),
    .sel(sel), .set_mode(set_mode), .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] outs();
    return {aHrT, aHrU, aMinT, aMinU, sel, set_mode, ringing, buzzer};
  endfunction

  function automatic logic [22:0] ev(input logic [3:0] ht, hu, mt, mu, s,
                                     input logic sm, rg, bz);
    return {ht, hu, mt, mu, s, sm, rg, bz};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic p_set, p_sel, p_inc, p_stop, p_snz);
    alarm_set = p_set; select = p_sel; increment = p_inc; stop = p_stop; snooze = p_snz;
    cyc();
    alarm_set = 0; select = 0; increment = 0; stop = 0; snooze = 0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic set_time(input logic [3:0] ht, hu, mt, mu, st, su);
    hrT = ht; hrU = hu; minT = mt; minU = mu; secT = st; secU = su;
  endtask

  task automatic test_reset();
    exp_t e;
    resetn = 1'b0;
    tick = 0; alarm_set = 0; select = 0; increment = 0; stop = 0; snooze = 0;
    alarm_en = 1'b1;
    set_time(0, 0, 0, 0, 0, 0);
    sb.push_back('{"reset_state", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0)});
    repeat (2) cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    resetn = 1'b1;
    sb.push_back('{"no_ring_at_0000", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0)});
    repeat (3) cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_set_alarm();
    exp_t e;
    sb.push_back('{"enter_set", ev(0, 0, 0, 0, 4'b0001, 1, 0, 0)});
    press(1, 0, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"inc_minT", ev(0, 0, 3, 0, 4'b0010, 1, 0, 0)});
    press(0, 1, 0, 0, 0);
    repeat (3) press(0, 0, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"inc_hrU", ev(0, 7, 3, 0, 4'b0100, 1, 0, 0)});
    press(0, 1, 0, 0, 0);
    repeat (7) press(0, 0, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"leave_set", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    press(1, 0, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_ring();
    exp_t e;
    set_time(0, 7, 2, 9, 5, 9);
    sb.push_back('{"pre_match", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    set_time(0, 7, 3, 0, 0, 0);
    sb.push_back('{"ring_start", ev(0, 7, 3, 0, 4'b0000, 0, 1, 1)});
    cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"beep_off", ev(0, 7, 3, 0, 4'b0000, 0, 1, 0)});
    do_ticks(1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"beep_on", ev(0, 7, 3, 0, 4'b0000, 0, 1, 1)});
    do_ticks(1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"ring_after_59", ev(0, 7, 3, 0, 4'b0000, 0, 1, 0)});
    do_ticks(57);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"auto_stop_60", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    do_ticks(1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_snooze();
    exp_t e;
    set_time(0, 7, 2, 9, 5, 9);
    cyc();
    set_time(0, 7, 3, 0, 0, 0);
    sb.push_back('{"re_ring", ev(0, 7, 3, 0, 4'b0000, 0, 1, 1)});
    cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"snoozed", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    press(0, 0, 0, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"snooze_299", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    do_ticks(299);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"snooze_expire", ev(0, 7, 3, 0, 4'b0000, 0, 1, 1)});
    do_ticks(1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"stopped", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    press(0, 0, 0, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_stop_snooze();
    exp_t e;
    set_time(0, 7, 2, 9, 5, 9);
    cyc();
    set_time(0, 7, 3, 0, 0, 0);
    cyc();
    sb.push_back('{"stop_beats_snooze", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    press(0, 0, 0, 1, 1);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"idle_not_snooze", ev(0, 7, 3, 0, 4'b0000, 0, 0, 0)});
    do_ticks(301);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_digits();
    exp_t e;
    press(1, 0, 0, 0, 0);
    repeat (2) press(0, 1, 0, 0, 0);
    repeat (2) press(0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    sb.push_back('{"hrT_1_hrU_9", ev(1, 9, 3, 0, 4'b1000, 1, 0, 0)});
    cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"hrT_to_2_clamps_hrU", ev(2, 3, 3, 0, 4'b1000, 1, 0, 0)});
    press(0, 0, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    repeat (3) press(0, 1, 0, 0, 0);
    sb.push_back('{"hrU_wrap_at_3", ev(2, 0, 3, 0, 4'b0100, 1, 0, 0)});
    press(0, 0, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    repeat (3) press(0, 1, 0, 0, 0);
    repeat (2) press(0, 0, 1, 0, 0);
    sb.push_back('{"minT_wrap_at_5", ev(2, 0, 0, 0, 4'b0010, 1, 0, 0)});
    press(0, 0, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"select_and_increment", ev(2, 0, 1, 0, 4'b0100, 1, 0, 0)});
    press(0, 1, 1, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    sb.push_back('{"exit_set", ev(2, 0, 1, 0, 4'b0000, 0, 0, 0)});
    press(1, 0, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    set_time(2, 0, 0, 9, 5, 9);
    cyc();
    set_time(2, 0, 1, 0, 0, 0);
    sb.push_back('{"ring_before_reset", ev(2, 0, 1, 0, 4'b0000, 0, 1, 1)});
    cyc();
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    #2;
    resetn = 1'b0;
    sb.push_back('{"async_reset_clears", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0)});
    #1;
    e = sb.pop_front(); n_cmp++;
    if (outs() !== e.v) begin n_mis++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.v); end
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_set_alarm();
    test_ring();
    test_snooze();
    test_stop_snooze();
    test_digits();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
